// File: rtl/ws2812_rx.sv
// ws2812_rx -- receive-side decoder for the single-wire WS2812 neopixel protocol.
//
// Each bit is classified by the width of its high pulse. Bits are packed MSB-first
// into 24-bit words, and each word is tagged with its LED index within the frame.
// Words are presented on a valid/ready stream.
//
// Ports:
//   CLK         system clock
//   resetn      synchronous, active-low reset
//   din         asynchronous WS2812 data line
//   rgb_data    received word; the first bit on the wire lands in [23]
//   led_num     0-based index of rgb_data within the current frame
//   valid       rgb_data/led_num hold a word that has not been taken yet
//   ready       consumer accepts the word when valid && ready
//   frame_done  1-cycle pulse when the frame-gap low time is reached after >=1 bit
//   bit_err     1-cycle pulse on an over-long high, or on a partial word at the frame gap
//   overrun     sticky; a completed word was dropped because valid was still set
module ws2812_rx #(
  parameter int T_THRESH     = 7,
  parameter int MIN_HIGH     = 2,
  parameter int MAX_HIGH     = 18,
  parameter int RESET_CYCLES = 600,
  parameter int CNT_W        = 16
) (
  input  logic        CLK,
  input  logic        resetn,
  input  logic        din,
  output logic [23:0] rgb_data,
  output logic [7:0]  led_num,
  output logic        valid,
  input  logic        ready,
  output logic        frame_done,
  output logic        bit_err,
  output logic        overrun
);

  localparam logic [CNT_W-1:0] T_C     = CNT_W'(T_THRESH);
  localparam logic [CNT_W-1:0] MIN_C   = CNT_W'(MIN_HIGH);
  localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_HIGH);
  localparam logic [CNT_W-1:0] RESET_C = CNT_W'(RESET_CYCLES);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;

  state_t           state_reg;
  state_t           ret_state_reg;   // state to resume after a rejected glitch
  logic             sync1_reg;
  logic             s_reg;
  logic             s_prev_reg;
  logic [CNT_W-1:0] hi_cnt_reg;
  logic [CNT_W-1:0] lo_cnt_reg;
  logic [23:0]      word_reg;
  logic [4:0]       bit_cnt_reg;
  logic [7:0]       idx_reg;

  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] hi_inc;
  logic [CNT_W-1:0] lo_inc;
  logic             bit_val;
  logic [23:0]      new_word;
  logic             word_done;

  assign rise      = s_reg & ~s_prev_reg;
  assign fall      = ~s_reg & s_prev_reg;
  assign hi_inc    = (hi_cnt_reg == '1) ? hi_cnt_reg : hi_cnt_reg + ONE_C;
  assign lo_inc    = (lo_cnt_reg == '1) ? lo_cnt_reg : lo_cnt_reg + ONE_C;
  // hi_cnt_reg holds the number of high cycles seen when the falling edge arrives
  assign bit_val   = (hi_cnt_reg >= T_C);
  assign new_word  = {word_reg[22:0], bit_val};
  assign word_done = (bit_cnt_reg == 5'd23);

  always_ff @(posedge CLK) begin
    if (!resetn) begin
      state_reg     <= SYNC;
      ret_state_reg <= IDLE;
      sync1_reg     <= 1'b0;
      s_reg         <= 1'b0;
      s_prev_reg    <= 1'b0;
      hi_cnt_reg    <= '0;
      lo_cnt_reg    <= '0;
      word_reg      <= '0;
      bit_cnt_reg   <= '0;
      idx_reg       <= '0;
      rgb_data      <= '0;
      led_num       <= '0;
      valid         <= 1'b0;
      frame_done    <= 1'b0;
      bit_err       <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      sync1_reg  <= din;
      s_reg      <= sync1_reg;
      s_prev_reg <= s_reg;
      frame_done <= 1'b0;
      bit_err    <= 1'b0;

      // A word load further down overrides this clear.
      if (valid && ready)
        valid <= 1'b0;

      case (state_reg)
        SYNC: begin
          // Any high resets the quiet-time count; only a full gap lets decoding start.
          if (s_reg) begin
            lo_cnt_reg <= '0;
          end else if (lo_inc == RESET_C) begin
            lo_cnt_reg <= '0;
            state_reg  <= IDLE;
          end else begin
            lo_cnt_reg <= lo_inc;
          end
        end

        IDLE: begin
          if (rise) begin
            hi_cnt_reg    <= ONE_C;
            ret_state_reg <= IDLE;
            state_reg     <= HIGH;
          end
        end

        HIGH: begin
          if (fall) begin
            if (hi_cnt_reg < MIN_C) begin
              // Glitch: drop it and resume; lo_cnt_reg was left untouched.
              state_reg <= ret_state_reg;
            end else begin
              lo_cnt_reg <= ONE_C;
              state_reg  <= LOW;
              if (word_done) begin
                bit_cnt_reg <= '0;
                word_reg    <= '0;
                if (!valid || ready) begin
                  rgb_data <= new_word;
                  led_num  <= idx_reg;
                  valid    <= 1'b1;
                end else begin
                  overrun <= 1'b1;
                end
                if (idx_reg != 8'hFF)
                  idx_reg <= idx_reg + 8'd1;
              end else begin
                word_reg    <= new_word;
                bit_cnt_reg <= bit_cnt_reg + 5'd1;
              end
            end
          end else if (hi_cnt_reg >= MAX_C) begin
            // This cycle is one more high cycle than allowed.
            bit_err     <= 1'b1;
            word_reg    <= '0;
            bit_cnt_reg <= '0;
            lo_cnt_reg  <= '0;
            state_reg   <= SYNC;
          end else begin
            hi_cnt_reg <= hi_inc;
          end
        end

        LOW: begin
          if (rise) begin
            hi_cnt_reg    <= ONE_C;
            ret_state_reg <= LOW;
            state_reg     <= HIGH;
          end else if (lo_inc == RESET_C) begin
            frame_done  <= 1'b1;
            idx_reg     <= '0;
            if (bit_cnt_reg != 5'd0)
              bit_err <= 1'b1;
            bit_cnt_reg <= '0;
            word_reg    <= '0;
            state_reg   <= IDLE;
          end else begin
            lo_cnt_reg <= lo_inc;
          end
        end

        default: state_reg <= SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_rx.sv
// tb_ws2812_rx -- self-checking bench for ws2812_rx with randomized bit timing.
// A bit-level model (word packing, LED index, frame/err accounting) produces the
// expected words and event counts; a monitor compares every accepted word.
module tb_ws2812_rx;

  logic        CLK = 1'b0;
  logic        resetn = 1'b0;
  logic        din = 1'b0;
  logic        ready = 1'b0;
  logic [23:0] rgb_data;
  logic [7:0]  led_num;
  logic        valid;
  logic        frame_done;
  logic        bit_err;
  logic        overrun;

  ws2812_rx dut (
    .CLK        (CLK),
    .resetn     (resetn),
    .din        (din),
    .rgb_data   (rgb_data),
    .led_num    (led_num),
    .valid      (valid),
    .ready      (ready),
    .frame_done (frame_done),
    .bit_err    (bit_err),
    .overrun    (overrun)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [23:0] w;
    logic [7:0]  n;
  } exp_t;

  exp_t        sb[$];
  int          m_idx = 0;
  int          m_wbits = 0;
  int          m_frame_bits = 0;
  int          m_fd = 0;
  int          m_err = 0;
  int          m_both = 0;
  bit          m_sync = 1'b1;
  bit          m_overrun = 1'b0;
  bit          m_held = 1'b0;
  logic [23:0] m_word = '0;

  task automatic m_bit(input bit b);
    exp_t e;
    if (m_sync) return;
    m_word = {m_word[22:0], b};
    m_wbits++;
    m_frame_bits++;
    if (m_wbits == 24) begin
      m_wbits = 0;
      if (ready || !m_held) begin
        e.w = m_word;
        e.n = m_idx[7:0];
        sb.push_back(e);
        if (!ready) m_held = 1'b1;
      end else begin
        m_overrun = 1'b1;
      end
      if (m_idx < 255) m_idx++;
    end
  endtask

  // ---------------- monitor ----------------
  int   fd_cnt = 0;
  int   err_cnt = 0;
  int   both_cnt = 0;
  int   xfer_cnt = 0;
  exp_t mon_e;
  logic mon_has;

  always @(negedge CLK) begin
    if (resetn) begin
      if (frame_done) fd_cnt++;
      if (bit_err) err_cnt++;
      if (frame_done && bit_err) both_cnt++;
      if (valid && ready) begin
        xfer_cnt++;
        mon_has = (sb.size() != 0);
        check("word_expected", {31'd0, mon_has}, 32'd1);
        if (mon_has) begin
          mon_e = sb.pop_front();
          $display("xfer %0d: rgb_data=%06h led_num=%0d (exp %06h / %0d)",
                   xfer_cnt, rgb_data, led_num, mon_e.w, mon_e.n);
          check("rgb_data", {8'd0, rgb_data}, {8'd0, mon_e.w});
          check("led_num", {24'd0, led_num}, {24'd0, mon_e.n});
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic send_bit(input bit b, input int hi, input int lo);
    din = 1'b1;
    tick(hi);
    din = 1'b0;
    m_bit(b);
    tick(lo);
  endtask

  // Random timing inside the unambiguous '0' / '1' bands; optional 1-cycle glitch in the low.
  task automatic rand_bit(input bit b, input bit glitch);
    int hi;
    hi = b ? int'($urandom_range(16, 7)) : int'($urandom_range(6, 2));
    if (glitch) begin
      din = 1'b1;
      tick(hi);
      din = 1'b0;
      m_bit(b);
      tick(3);
      din = 1'b1;
      tick(1);
      din = 1'b0;
      tick(4);
    end else begin
      send_bit(b, hi, int'($urandom_range(12, 2)));
    end
  endtask

  task automatic send_word(input logic [23:0] w, input int glitch_pct);
    for (int i = 23; i >= 0; i--)
      rand_bit(w[i], ($urandom_range(99, 0) < glitch_pct));
  endtask

  task automatic gap();
    din = 1'b0;
    tick(610);
    if (!m_sync && m_frame_bits > 0) begin
      m_fd++;
      if (m_wbits != 0) begin
        m_err++;
        m_both++;
      end
    end
    m_sync = 1'b0;
    m_idx = 0;
    m_wbits = 0;
    m_frame_bits = 0;
    m_word = '0;
  endtask

  task automatic long_high();
    din = 1'b1;
    tick(20);
    din = 1'b0;
    tick(3);
    if (!m_sync) m_err++;
    m_sync = 1'b1;
    m_wbits = 0;
    m_frame_bits = 0;
    m_word = '0;
  endtask

  task automatic set_ready(input logic r);
    ready = r;
    if (r) m_held = 1'b0;
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_frame_done"}, fd_cnt, m_fd);
    check({tag, "_bit_err"}, err_cnt, m_err);
    check({tag, "_coincident"}, both_cnt, m_both);
    check({tag, "_overrun"}, {31'd0, overrun}, {31'd0, m_overrun});
    check({tag, "_pending"}, sb.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rgb_data"}, {8'd0, rgb_data}, 32'd0);
    check({tag, "_led_num"}, {24'd0, led_num}, 32'd0);
    check({tag, "_valid"}, {31'd0, valid}, 32'd0);
    check({tag, "_frame_done"}, {31'd0, frame_done}, 32'd0);
    check({tag, "_bit_err"}, {31'd0, bit_err}, 32'd0);
    check({tag, "_overrun"}, {31'd0, overrun}, 32'd0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  logic [23:0] w1, w2, w3, pat;
  int          nb;

  initial begin
    resetn = 1'b0;
    din    = 1'b0;
    ready  = 1'b0;
    tick(4);
    check_reset_outputs("reset");
    resetn = 1'b1;

    // 1: fixed 0xFF0055, latency and hold with ready low
    gap();
    pat = 24'hFF0055;
    for (int i = 23; i >= 1; i--)
      send_bit(pat[i], pat[i] ? 10 : 5, pat[i] ? 5 : 10);
    din = 1'b1;
    tick(pat[0] ? 10 : 5);
    din = 1'b0;
    m_bit(pat[0]);
    tick(2);
    check("t1_valid_early", {31'd0, valid}, 32'd0);
    tick(1);
    check("t1_valid_lat3", {31'd0, valid}, 32'd1);
    check("t1_rgb_data", {8'd0, rgb_data}, 32'hFF0055);
    check("t1_led_num", {24'd0, led_num}, 32'd0);
    tick(5);
    check("t1_hold_rgb", {8'd0, rgb_data}, 32'hFF0055);
    set_ready(1'b1);
    tick(2);
    gap();
    check_counts("t1");

    // 2: seven random words, ready high
    for (int k = 0; k < 7; k++)
      send_word(24'($urandom), 0);
    gap();
    check_counts("t2");

    // 3: two words with ready low -> first held, second dropped
    set_ready(1'b0);
    w1 = 24'($urandom);
    w2 = 24'($urandom);
    send_word(w1, 0);
    send_word(w2, 0);
    tick(5);
    check("t3_valid", {31'd0, valid}, 32'd1);
    check("t3_hold_rgb", {8'd0, rgb_data}, {8'd0, w1});
    check("t3_hold_led", {24'd0, led_num}, 32'd0);
    check("t3_overrun", {31'd0, overrun}, 32'd1);
    set_ready(1'b1);
    tick(3);
    gap();
    w3 = 24'($urandom);
    send_word(w3, 0);
    gap();
    check_counts("t3");

    // 4: partial word (12 bits) at the frame gap, then a good frame
    for (int i = 0; i < 12; i++)
      rand_bit(1'($urandom), 1'b0);
    gap();
    send_word(24'($urandom), 0);
    gap();
    check_counts("t4");

    // 5: glitches (idle and inside lows), then over-long high and resync
    din = 1'b1;
    tick(1);
    din = 1'b0;
    tick(5);
    send_word(24'($urandom), 40);
    gap();
    check_counts("t5a");
    long_high();
    send_word(24'($urandom), 0);
    gap();
    check_counts("t5b");
    send_word(24'($urandom), 0);
    gap();
    check_counts("t5c");

    // 6: reset after bit 10, then resync before decoding
    for (int i = 0; i < 10; i++)
      rand_bit(1'($urandom), 1'b0);
    din    = 1'b0;
    resetn = 1'b0;
    tick(3);
    check_reset_outputs("t6_reset");
    sb.delete();
    m_sync = 1'b1;
    m_idx = 0;
    m_wbits = 0;
    m_frame_bits = 0;
    m_word = '0;
    m_overrun = 1'b0;
    m_held = 1'b0;
    resetn = 1'b1;
    send_word(24'($urandom), 0);
    gap();
    send_word(24'($urandom), 0);
    gap();
    check_counts("t6");

    // random frames: random word counts, glitches and partial tails
    for (int f = 0; f < 4; f++) begin
      nb = int'($urandom_range(4, 1));
      for (int k = 0; k < nb; k++)
        send_word(24'($urandom), 20);
      if ($urandom_range(1, 0) == 1) begin
        nb = int'($urandom_range(23, 1));
        for (int i = 0; i < nb; i++)
          rand_bit(1'($urandom), 1'b0);
      end
      gap();
      check_counts("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
